dot_product_unit: RTL and testbench

//  Streaming signed dot-product engine for the matrix multiplier datapath.

---
 rtl/project_pkg.sv | 29 ++
 rtl/dot_product_unit_if.sv | 26 ++
 rtl/dpu_mult_stage.sv | 23 ++
 rtl/dot_product_unit.sv | 102 ++++++++++
 tb/tb_dot_product_unit.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/project_pkg.sv
// Shared types and sizing for the matrix multiplier datapath.
// Holds the dot-product unit state encoding and operand typedefs.
package project_pkg;

    localparam int MSB   = 32;
    localparam int DW    = MSB;
    localparam int K_MAX = 16;
    localparam int LW    = $clog2(K_MAX + 1);
    localparam int ACC_W = 2 * DW + $clog2(K_MAX);

    typedef enum logic [1:0] {
        DPU_IDLE,
        DPU_ACC,
        DPU_FLUSH,
        DPU_HOLD
    } dpu_state_t;

    typedef logic signed [MSB-1:0] operand_t;

    // Zero-length vectors still consume one beat; oversize ones are capped.
    function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
        if (l == '0)
            return LW'(1);
        if (l > LW'(K_MAX))
            return LW'(K_MAX);
        return l;
    endfunction

endpackage

// File: rtl/dot_product_unit_if.sv
// Operand-in / result-out handshake bundle of the dot-product unit.
interface dot_product_unit_if
    import project_pkg::*;
();

    logic [LW-1:0]           len;
    logic                    in_valid;
    logic                    in_ready;
    operand_t                in_a;
    operand_t                in_b;
    logic                    res_valid;
    logic                    res_ready;
    logic signed [ACC_W-1:0] res_data;
    logic                    busy;

    modport master (
        output len, in_valid, in_a, in_b, res_ready,
        input  in_ready, res_valid, res_data, busy
    );

    modport slave (
        input  len, in_valid, in_a, in_b, res_ready,
        output in_ready, res_valid, res_data, busy
    );

endinterface

// File: rtl/dpu_mult_stage.sv
// Registered signed multiplier; kept separate so it can be retimed
// or swapped for a DSP macro without touching the control path.
module dpu_mult_stage
    import project_pkg::*;
#(
    parameter int W = DW
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic signed [W-1:0]   a,
    input  logic signed [W-1:0]   b,
    output logic signed [2*W-1:0] p
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            p <= '0;
        else if (en)
            p <= a * b;
    end

endmodule

// File: rtl/dot_product_unit.sv
// Streaming signed dot-product engine: one operand pair per beat,
// one full-precision result per vector.
module dot_product_unit
    import project_pkg::*;
(
    input logic               clk,
    input logic               rst,
    dot_product_unit_if.slave bus
);

    dpu_state_t              state;
    dpu_state_t              state_nxt;
    logic [LW-1:0]           len_q;
    logic [LW-1:0]           cnt;
    logic signed [2*DW-1:0]  p_q;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_nxt;
    logic signed [ACC_W-1:0] res_q;
    logic                    acc_en;
    logic                    in_ready;
    logic                    res_valid;
    logic                    accept;

    assign accept = bus.in_valid & in_ready;

    dpu_mult_stage #(.W(DW)) u_mult (
        .clk (clk),
        .rst (rst),
        .en  (accept),
        .a   (bus.in_a),
        .b   (bus.in_b),
        .p   (p_q)
    );

    assign acc_nxt = acc + {{(ACC_W-2*DW){p_q[2*DW-1]}}, p_q};

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        unique case (state)
            DPU_IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid)
                    state_nxt = (clamp_len(bus.len) == LW'(1))
                              ? DPU_FLUSH : DPU_ACC;
            end
            DPU_ACC: begin
                in_ready = 1'b1;
                if (bus.in_valid && (cnt + LW'(1)) == len_q)
                    state_nxt = DPU_FLUSH;
            end
            DPU_FLUSH: begin
                state_nxt = DPU_HOLD;
            end
            DPU_HOLD: begin
                res_valid = 1'b1;
                if (bus.res_ready)
                    state_nxt = DPU_IDLE;
            end
            default: state_nxt = DPU_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= DPU_IDLE;
        else
            state <= state_nxt;
    end

    // acc is cleared on the first beat so the delayed add starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q  <= '0;
            cnt    <= '0;
            acc    <= '0;
            acc_en <= 1'b0;
            res_q  <= '0;
        end else begin
            acc_en <= accept;
            if (state == DPU_IDLE && accept) begin
                len_q <= clamp_len(bus.len);
                cnt   <= LW'(1);
                acc   <= '0;
            end else begin
                if (state == DPU_ACC && accept)
                    cnt <= cnt + LW'(1);
                if (acc_en)
                    acc <= acc_nxt;
            end
            if (state == DPU_FLUSH)
                res_q <= acc_nxt;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.res_valid = res_valid;
    assign bus.res_data  = res_q;
    assign bus.busy      = (state != DPU_IDLE);

endmodule

// File: tb/tb_dot_product_unit.sv
// Directed-vector bench for dot_product_unit.
module tb_dot_product_unit;
    import project_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    dot_product_unit_if bus();

    dot_product_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic beat(input operand_t a, input operand_t b,
                        input logic [LW-1:0] l);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.len      = l;
    endtask

    task automatic stall();
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_a     = 32'sd99;
        bus.in_b     = 32'sd99;
    endtask

    task automatic get_res(input string tag, input logic [ACC_W-1:0] exp);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (!bus.res_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_vld"}, 128'(bus.res_valid), 128'(1));
        chk(tag, 128'(bus.res_data), 128'(exp));
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst           = 1'b1;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.res_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
        chk("rst_res_valid", 128'(bus.res_valid), 128'(0));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_res_data", 128'(bus.res_data), 128'(0));
        rst = 1'b0;

        // 1) basic 3-beat vector and latency
        beat(1, 4, 3);
        beat(2, 5, 3);
        beat(3, 6, 3);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("t1_flush_vld", 128'(bus.res_valid), 128'(0));
        chk("t1_flush_rdy", 128'(bus.in_ready), 128'(0));
        chk("t1_flush_busy", 128'(bus.busy), 128'(1));
        @(negedge clk);
        chk("t1_hold_vld", 128'(bus.res_valid), 128'(1));
        chk("t1_data", 128'(bus.res_data), 128'(32));
        @(negedge clk);
        chk("t1_done_vld", 128'(bus.res_valid), 128'(0));
        chk("t1_done_busy", 128'(bus.busy), 128'(0));

        // 2) wide signed operands, then no carry-over
        beat(-7, 3, 2);
        beat(32'sh7FFFFFFF, 2, 2);
        get_res("t2a", 68'd4294967273);
        beat(32'sh80000000, 32'sh80000000, 1);
        get_res("t2b", 68'h4000_0000_0000_0000);

        // 3) stalls between beats; later len changes ignored
        beat(1, 1, 4);
        stall();
        chk("t3_stall_rdy", 128'(bus.in_ready), 128'(1));
        chk("t3_stall_busy", 128'(bus.busy), 128'(1));
        beat(1, 1, 2);
        stall();
        beat(1, 1, 2);
        stall();
        beat(1, 1, 2);
        get_res("t3", 68'd4);

        // 4) result backpressure
        bus.res_ready = 1'b0;
        beat(3, 5, 2);
        beat(4, 6, 2);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = 32'sd100;
        bus.in_b     = 32'sd100;
        bus.len      = 5'd1;
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_vld", 128'(bus.res_valid), 128'(1));
            chk("t4_hold_data", 128'(bus.res_data), 128'(39));
            chk("t4_hold_rdy", 128'(bus.in_ready), 128'(0));
            @(negedge clk);
        end
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        chk("t4_rel_vld", 128'(bus.res_valid), 128'(0));
        chk("t4_rel_busy", 128'(bus.busy), 128'(0));
        chk("t4_rel_rdy", 128'(bus.in_ready), 128'(1));
        chk("t4_rel_data", 128'(bus.res_data), 128'(39));

        // 5) reset mid-vector
        beat(1, 1, 4);
        beat(1, 1, 4);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk("t5_pre_busy", 128'(bus.busy), 128'(1));
        rst = 1'b1;
        #1;
        chk("t5_rst_vld", 128'(bus.res_valid), 128'(0));
        chk("t5_rst_busy", 128'(bus.busy), 128'(0));
        chk("t5_rst_rdy", 128'(bus.in_ready), 128'(1));
        chk("t5_rst_data", 128'(bus.res_data), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        beat(2, 2, 2);
        beat(3, 3, 2);
        get_res("t5", 68'd13);

        // 6) len=0 treated as 1; len=20 clamped to 16
        beat(5, 6, 0);
        get_res("t6a", 68'd30);
        for (int i = 0; i < 16; i++)
            beat(1, 1, 5'd20);
        get_res("t6b", 68'd16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
